// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit:
// funct3 opcodes and the controller state encoding.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Bit-serial RV32M/RV64M multiply/divide unit: one op at a time, one bit per
// cycle on operand magnitudes, sign fixed up at the end.
//
// state | meaning
// IDLE  | waiting for an M op; accepts or resolves special cases directly
// CALC  | XLEN shift-add (mul) or restoring shift-subtract (div) steps
// FIX   | apply recorded sign, select half/quotient/remainder, register result
// DONE  | valid_out pulse; held instruction advances, never re-accepted
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            stall_req,
  output logic            valid_out,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          rd_out_q, rd_out_d;

  logic                sign_a, sign_b, a_signed, b_signed, neg_acc;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_val;

  assign sign_a   = operand_a[XLEN-1];
  assign sign_b   = operand_b[XLEN-1];
  assign a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                    (funct3 == OP_DIV)  || (funct3 == OP_REM);
  assign b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
  assign mag_a    = (a_signed && sign_a) ? -operand_a : operand_a;
  assign mag_b    = (b_signed && sign_b) ? -operand_b : operand_b;

  always_comb begin
    neg_acc = 1'b0;
    case (funct3)
      OP_MULH, OP_DIV:   neg_acc = sign_a ^ sign_b;
      OP_MULHSU, OP_REM: neg_acc = sign_a;
      default:           neg_acc = 1'b0;
    endcase
  end

  // funct3[1] separates REM/REMU from DIV/DIVU within the divide group
  assign div_zero    = funct3[2] && (operand_b == '0);
  assign div_ovf     = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                       (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
  assign special     = div_zero || div_ovf;
  assign special_val = div_zero ? (funct3[1] ? operand_a : '1)
                                : (funct3[1] ? '0 : operand_a);

  // One iteration of each datapath over the shared accumulator
  logic [XLEN:0]     add_sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_mul, acc_div;

  assign add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign acc_mul = {add_sum, acc_q[XLEN-1:1]};
  assign rem_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign diff    = rem_sh - {1'b0, opb_q};
  assign acc_div = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, fix_val;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo      = acc_q[XLEN-1:0];
  assign rem      = acc_q[2*XLEN-1:XLEN];
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = neg_q ? -rem : rem;

  always_comb begin
    fix_val = '0;
    case (op_q)
      OP_MUL:                       fix_val = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_val = quo_fix;
      OP_REM, OP_REMU:              fix_val = rem_fix;
      default:                      fix_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            op_d  = funct3;
            rd_d  = rd_in;
            neg_d = neg_acc;
            cnt_d = CW'(XLEN - 1);
            acc_d = {{XLEN{1'b0}}, mag_a};
            opb_d = mag_b;
            if (special) begin
              result_d = special_val;
              rd_out_d = rd_in;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = op_q[2] ? acc_div : acc_mul;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = ST_FIX;
        end
        ST_FIX: begin
          result_d = fix_val;
          rd_out_d = rd_q;
          state_d  = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign valid_out = (state_q == ST_DONE);
  assign stall_req = valid_in && (state_q != ST_DONE);
  assign result    = result_q;
  assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: XLEN=32 instance driven with directed and
// random ops against an arithmetic reference model, plus an XLEN=16 instance.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in;
  logic [2:0]  funct3;
  logic [31:0] operand_a, operand_b, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, stall_req, valid_out;

  logic        v16, flush16, busy16, stall16, vo16;
  logic [2:0]  f16;
  logic [15:0] a16, b16, res16;
  logic [4:0]  rd16, rdo16;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .funct3(funct3), .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .stall_req(stall_req), .valid_out(valid_out),
    .result(result), .rd_out(rd_out)
  );

  muldiv_unit #(.XLEN(16)) u_dut16 (
    .clk(clk), .reset(reset), .flush(flush16), .valid_in(v16),
    .funct3(f16), .operand_a(a16), .operand_b(b16), .rd_in(rd16),
    .busy(busy16), .stall_req(stall16), .valid_out(vo16),
    .result(res16), .rd_out(rdo16)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
    int          busy;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, ub;
    logic [63:0] p;
    int          ia, ib;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ia  = a;
    ib  = b;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result
  initial begin
    int  busy_cnt = 0;
    bit  vo_prev  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (valid_out) begin
        if (vo_prev) check("valid_twice", 1, 0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("rd_out", rd_out, e.rd);
          check("latency", cyc - e.acc + 1, e.lat);
          check("busy_cycles", busy_cnt, e.busy);
          check("stall_in_done", stall_req, 0);
        end
        busy_cnt = 0;
      end
      if (reset || flush) busy_cnt = 0;
      vo_prev = valid_out;
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    int   k;
    funct3 = f; operand_a = a; operand_b = b; rd_in = rd; valid_in = 1'b1;
    @(posedge clk); #1;
    e.res  = ref_op(f, a, b);
    e.rd   = rd;
    e.acc  = cyc;
    e.lat  = is_special(f, a, b) ? 1 : 34;
    e.busy = is_special(f, a, b) ? 0 : 33;
    sb.push_back(e);
    last_res = e.res;
    last_rd  = rd;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid_out) break;
    end
    if (k == 100) check("timeout_valid_out", 0, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic run16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expv, input int explat);
    int k;
    f16 = f; a16 = a; b16 = b; rd16 = 5'd9; v16 = 1'b1;
    @(posedge clk); #1;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (vo16) break;
    end
    check("x16_latency", k, explat);
    check("x16_result", res16, expv);
    check("x16_rd_out", rdo16, 5'd9);
    @(posedge clk); #1;
    v16 = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0;
    funct3 = '0; operand_a = '0; operand_b = '0; rd_in = '0;
    v16 = 1'b0; flush16 = 1'b0; f16 = '0; a16 = '0; b16 = '0; rd16 = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_result", result, 0);
    check("rst_rd_out", rd_out, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10);
    run_op(3'd5, 32'd100,       32'd7,         5'd11);
    run_op(3'd7, 32'd100,       32'd7,         5'd12);
    run_op(3'd5, 32'd5,         32'd0,         5'd13);
    run_op(3'd6, 32'd5,         32'd0,         5'd14);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

    // Flush in CALC cycle 10: no result, outputs hold
    funct3 = 3'd0; operand_a = 32'd123456; operand_b = 32'd789; rd_in = 5'd20; valid_in = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    check("flush_busy_before", busy, 1);
    flush = 1'b1; valid_in = 1'b0;
    #1 check("flush_stall_low", stall_req, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle_busy", busy, 0);
    check("flush_result_hold", result, last_res);
    check("flush_rd_hold", rd_out, last_rd);
    repeat (5) @(posedge clk);
    #1;
    run_op(3'd0, 32'd3, 32'd4, 5'd21);

    repeat (150) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(f, a, b, 5'($urandom));
    end

    // Asynchronous reset in the middle of CALC
    funct3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd30; valid_in = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; valid_in = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid_out", valid_out, 0);
    check("arst_result", result, 0);
    check("arst_rd_out", rd_out, 0);
    check("arst_stall", stall_req, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_op(3'd5, 32'd100, 32'd7, 5'd31);

    run16(3'd0, 16'h00FF, 16'h0101, 16'hFFFF, 18);
    run16(3'd5, 16'hFFFF, 16'h0010, 16'h0FFF, 18);
    run16(3'd6, 16'h8000, 16'hFFFF, 16'h0000, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
